// File: rtl/cr_iu_wb_buf_pkg.sv
// rtl/cr_iu_wb_buf_pkg.sv - shared state encoding and post-retire fault vectors
package cr_iu_wb_buf_pkg;

   typedef enum logic [1:0] {
      WB_IDLE    = 2'b00,
      WB_LD_PEND = 2'b01,
      WB_ST_PEND = 2'b10,
      WB_ERR     = 2'b11
   } wb_state_e;

   localparam logic [4:0] LD_ACC_VEC = 5'd5;
   localparam logic [4:0] ST_ACC_VEC = 5'd7;

endpackage

// File: rtl/cr_iu_wb_hazard.sv
// rtl/cr_iu_wb_hazard.sv - RAW compare of EX sources against the pending load destination
module cr_iu_wb_hazard (
   input  logic       ex_vld_i,
   input  logic       ld_pend_i,
   input  logic [4:0] src0_reg_i,
   input  logic [4:0] src1_reg_i,
   input  logic [4:0] pend_reg_i,
   output logic       raw_stall_o
);

   logic src_hit;

   // x0 never carries a dependency, so a load targeting it cannot stall EX
   assign src_hit     = (src0_reg_i == pend_reg_i) || (src1_reg_i == pend_reg_i);
   assign raw_stall_o = ex_vld_i && ld_pend_i && (pend_reg_i != 5'd0) && src_hit;

endmodule

// File: rtl/cr_iu_wb_buf.sv
// rtl/cr_iu_wb_buf.sv - write-back buffer: GPR write port and one outstanding fast-retired access
module cr_iu_wb_buf
   import cr_iu_wb_buf_pkg::*;
(
   input  logic        forever_cpuclk,
   input  logic        cpurst_b,
   input  logic        rbus_wb_cmplt,
   input  logic [31:0] rbus_wb_data,
   input  logic [4:0]  rbus_wb_dst_reg,
   input  logic        rbus_wb_inst_cmplt,
   input  logic        rbus_wb_load,
   input  logic        rbus_wb_store,
   input  logic        lsu_wb_resp_vld,
   input  logic        lsu_wb_resp_err,
   input  logic [4:0]  ifu_wb_ex_src0_reg,
   input  logic [4:0]  ifu_wb_ex_src1_reg,
   input  logic        ifu_wb_ex_vld,
   output logic        wb_rf_wen,
   output logic [4:0]  wb_rf_waddr,
   output logic [31:0] wb_rf_wdata,
   output logic        wb_rbus_st_aft_load,
   output logic [4:0]  wb_rbus_lsu_vec,
   output logic        wb_xx_acc_err_after_retire,
   output logic        wb_ctrl_stall,
   output logic        wb_xx_ld_pend
);

   wb_state_e  state_q, state_d;
   logic [4:0] pend_reg_q, pend_reg_d;
   logic [4:0] vec_q, vec_d;

   logic       is_pend;
   logic       resp_ok;
   logic       resp_bad;
   logic       st_aft_load;
   logic       can_accept;
   logic       fr_req;
   logic       raw_stall;
   logic       wen_raw;
   logic [4:0] waddr_raw;
   logic       unused_inst_cmplt;

   // Instruction-complete strobe is not needed by this buffer's control
   assign unused_inst_cmplt = rbus_wb_inst_cmplt;

   assign is_pend     = (state_q == WB_LD_PEND) || (state_q == WB_ST_PEND);
   assign resp_ok     = is_pend && lsu_wb_resp_vld && !lsu_wb_resp_err;
   assign resp_bad    = is_pend && lsu_wb_resp_vld && lsu_wb_resp_err;
   assign st_aft_load = (state_q == WB_LD_PEND) && lsu_wb_resp_vld && !lsu_wb_resp_err;
   assign fr_req      = rbus_wb_load || rbus_wb_store;
   assign can_accept  = (state_q == WB_IDLE) || resp_ok;

   always_comb begin
      state_d    = state_q;
      pend_reg_d = pend_reg_q;
      vec_d      = vec_q;
      if (state_q == WB_ERR) begin
         state_d    = WB_IDLE;
         pend_reg_d = 5'd0;
         vec_d      = 5'd0;
      end else if (resp_bad) begin
         state_d = WB_ERR;
         vec_d   = (state_q == WB_LD_PEND) ? LD_ACC_VEC : ST_ACC_VEC;
      end else if (can_accept) begin
         // Load wins if both strobes arrive together
         if (rbus_wb_load) begin
            state_d    = WB_LD_PEND;
            pend_reg_d = rbus_wb_dst_reg;
         end else if (rbus_wb_store) begin
            state_d    = WB_ST_PEND;
            pend_reg_d = 5'd0;
         end else begin
            state_d    = WB_IDLE;
            pend_reg_d = 5'd0;
         end
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q    <= WB_IDLE;
         pend_reg_q <= 5'd0;
         vec_q      <= 5'd0;
      end else begin
         state_q    <= state_d;
         pend_reg_q <= pend_reg_d;
         vec_q      <= vec_d;
      end
   end

   cr_iu_wb_hazard u_hazard (
      .ex_vld_i    (ifu_wb_ex_vld),
      .ld_pend_i   (state_q == WB_LD_PEND),
      .src0_reg_i  (ifu_wb_ex_src0_reg),
      .src1_reg_i  (ifu_wb_ex_src1_reg),
      .pend_reg_i  (pend_reg_q),
      .raw_stall_o (raw_stall)
   );

   // Returning load borrows the rbus data path and owns the single write port
   always_comb begin
      wen_raw   = 1'b0;
      waddr_raw = 5'd0;
      if (st_aft_load) begin
         wen_raw   = 1'b1;
         waddr_raw = pend_reg_q;
      end else if (rbus_wb_cmplt && (state_q != WB_ERR)) begin
         wen_raw   = 1'b1;
         waddr_raw = rbus_wb_dst_reg;
      end
   end

   always_comb begin
      wb_rf_wen                  = 1'b0;
      wb_rf_waddr                = 5'd0;
      wb_rf_wdata                = 32'd0;
      wb_rbus_st_aft_load        = 1'b0;
      wb_rbus_lsu_vec            = 5'd0;
      wb_xx_acc_err_after_retire = 1'b0;
      wb_ctrl_stall              = 1'b0;
      wb_xx_ld_pend              = 1'b0;
      if (cpurst_b) begin
         wb_rf_wen                  = wen_raw && (waddr_raw != 5'd0);
         wb_rf_waddr                = waddr_raw;
         wb_rf_wdata                = wen_raw ? rbus_wb_data : 32'd0;
         wb_rbus_st_aft_load        = st_aft_load;
         wb_rbus_lsu_vec            = (state_q == WB_ERR) ? vec_q : 5'd0;
         wb_xx_acc_err_after_retire = (state_q == WB_ERR);
         wb_ctrl_stall              = st_aft_load
                                   || (fr_req && is_pend && !lsu_wb_resp_vld)
                                   || raw_stall
                                   || (state_q == WB_ERR);
         wb_xx_ld_pend              = (state_q == WB_LD_PEND);
      end
   end

endmodule

// File: tb/tb_cr_iu_wb_buf.sv
// tb/tb_cr_iu_wb_buf.sv - directed self-checking bench for cr_iu_wb_buf
module tb_cr_iu_wb_buf;

   logic        clk;
   logic        rst_n;
   logic        cmplt;
   logic [31:0] data;
   logic [4:0]  dst;
   logic        inst_cmplt;
   logic        ld;
   logic        st;
   logic        resp_vld;
   logic        resp_err;
   logic [4:0]  src0;
   logic [4:0]  src1;
   logic        ex_vld;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        st_aft;
   logic [4:0]  vec;
   logic        acc_err;
   logic        stall;
   logic        ld_pend;

   int n_chk;
   int n_fail;

   cr_iu_wb_buf dut (
      .forever_cpuclk             (clk),
      .cpurst_b                   (rst_n),
      .rbus_wb_cmplt              (cmplt),
      .rbus_wb_data               (data),
      .rbus_wb_dst_reg            (dst),
      .rbus_wb_inst_cmplt         (inst_cmplt),
      .rbus_wb_load               (ld),
      .rbus_wb_store              (st),
      .lsu_wb_resp_vld            (resp_vld),
      .lsu_wb_resp_err            (resp_err),
      .ifu_wb_ex_src0_reg         (src0),
      .ifu_wb_ex_src1_reg         (src1),
      .ifu_wb_ex_vld              (ex_vld),
      .wb_rf_wen                  (wen),
      .wb_rf_waddr                (waddr),
      .wb_rf_wdata                (wdata),
      .wb_rbus_st_aft_load        (st_aft),
      .wb_rbus_lsu_vec            (vec),
      .wb_xx_acc_err_after_retire (acc_err),
      .wb_ctrl_stall              (stall),
      .wb_xx_ld_pend              (ld_pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0; cmplt = 1'b1; data = 32'hDEAD_BEEF; dst = 5'd3; inst_cmplt = 1'b0;
      ld = 1'b0; st = 1'b0; resp_vld = 1'b0; resp_err = 1'b0;
      src0 = 5'd0; src1 = 5'd0; ex_vld = 1'b0;
      settle();
      chk("rst_wen", wen, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_stall", stall, 0);
      chk("rst_ld_pend", ld_pend, 0);
      chk("rst_acc_err", acc_err, 0);
      chk("rst_vec", vec, 0);
      tick(); tick();
      rst_n = 1'b1;

      // Plain rbus write, then a write to x0
      data = 32'hA5A5_0001; dst = 5'd3; settle();
      chk("wr3_wen", wen, 1);
      chk("wr3_waddr", waddr, 3);
      chk("wr3_wdata", wdata, 32'hA5A5_0001);
      chk("wr3_stall", stall, 0);
      dst = 5'd0; settle();
      chk("wr0_wen", wen, 0);

      // Load to r9, RAW checks, then good response
      cmplt = 1'b0; inst_cmplt = 1'b1; ld = 1'b1; dst = 5'd9; settle();
      chk("ld_issue_stall", stall, 0);
      tick();
      ld = 1'b0; inst_cmplt = 1'b0; ex_vld = 1'b1; src1 = 5'd9; settle();
      chk("ld_pend", ld_pend, 1);
      chk("raw_src1", stall, 1);
      tick();
      src1 = 5'd0; settle();
      chk("raw_src0_zero", stall, 0);
      src1 = 5'd10; settle();
      chk("raw_src10", stall, 0);
      src0 = 5'd9; settle();
      chk("raw_src0", stall, 1);
      tick();
      chk("raw_hold", stall, 1);
      ex_vld = 1'b0; src0 = 5'd0; src1 = 5'd0;
      resp_vld = 1'b1; data = 32'h1234_5678; dst = 5'd1; settle();
      chk("ldret_st_aft", st_aft, 1);
      chk("ldret_stall", stall, 1);
      chk("ldret_wen", wen, 1);
      chk("ldret_waddr", waddr, 9);
      chk("ldret_wdata", wdata, 32'h1234_5678);
      tick();
      resp_vld = 1'b0; settle();
      chk("ldret_idle_pend", ld_pend, 0);
      chk("ldret_idle_stall", stall, 0);
      chk("ldret_idle_st_aft", st_aft, 0);

      // Store, blocked new load, error response, ERR cycle
      st = 1'b1; tick();
      st = 1'b0; ld = 1'b1; dst = 5'd11; settle();
      chk("st_busy_stall", stall, 1);
      tick();
      ld = 1'b0; settle();
      chk("st_busy_not_acc", ld_pend, 0);
      resp_vld = 1'b1; resp_err = 1'b1; settle();
      chk("sterr_acc_err_now", acc_err, 0);
      tick();
      resp_vld = 1'b0; resp_err = 1'b0; cmplt = 1'b1; dst = 5'd4; data = 32'h0000_0044; settle();
      chk("sterr_acc_err", acc_err, 1);
      chk("sterr_vec", vec, 7);
      chk("sterr_wen", wen, 0);
      chk("sterr_stall", stall, 1);
      tick();
      chk("sterr_1cyc", acc_err, 0);
      chk("sterr_vec_clr", vec, 0);
      chk("post_err_wen", wen, 1);
      cmplt = 1'b0;

      // Load response coincident with a new store
      ld = 1'b1; dst = 5'd12; tick();
      ld = 1'b0; resp_vld = 1'b1; st = 1'b1; data = 32'hCAFE_BABE; dst = 5'd2; settle();
      chk("ldst_st_aft", st_aft, 1);
      chk("ldst_waddr", waddr, 12);
      chk("ldst_wdata", wdata, 32'hCAFE_BABE);
      chk("ldst_stall", stall, 1);
      tick();
      resp_vld = 1'b0; st = 1'b0; settle();
      chk("ldst_not_ld", ld_pend, 0);
      chk("ldst_nostall", stall, 0);
      ld = 1'b1; dst = 5'd13; settle();
      chk("ldst_in_st_pend", stall, 1);
      resp_vld = 1'b1; settle();
      chk("st_resp_accept", stall, 0);
      chk("st_resp_no_st_aft", st_aft, 0);
      tick();
      ld = 1'b0; resp_vld = 1'b0; settle();
      chk("reload_pend", ld_pend, 1);

      // Load error
      resp_vld = 1'b1; resp_err = 1'b1; data = 32'h5555_5555; settle();
      chk("lderr_wen", wen, 0);
      chk("lderr_st_aft", st_aft, 0);
      tick();
      resp_vld = 1'b0; resp_err = 1'b0; settle();
      chk("lderr_acc_err", acc_err, 1);
      chk("lderr_vec", vec, 5);
      chk("lderr_ld_pend", ld_pend, 0);
      tick();
      chk("lderr_done", acc_err, 0);

      // Reset mid-wait drops the pending load
      ld = 1'b1; dst = 5'd9; tick();
      ld = 1'b0; settle();
      chk("rst2_pend_before", ld_pend, 1);
      cmplt = 1'b1; dst = 5'd3; rst_n = 1'b0; settle();
      chk("rst2_wen", wen, 0);
      chk("rst2_ld_pend", ld_pend, 0);
      chk("rst2_stall", stall, 0);
      tick();
      rst_n = 1'b1; cmplt = 1'b0; resp_vld = 1'b1; data = 32'h7777_7777; settle();
      chk("rst2_resp_wen", wen, 0);
      chk("rst2_resp_st_aft", st_aft, 0);
      tick();
      resp_vld = 1'b0; settle();
      chk("rst2_no_err", acc_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
